write_out_tiled: RTL and testbench

Successor output writer for the systolic array: accepts diagonal-skewed result vectors over a valid/ready handshake and de-skews them into a parameterised bank of output SRAMs. It tracks diagonal and tile position internally instead of taking a matrix index, so the producer supplies only data and the data set. It handles any number of data sets, multi-tile address depth and downstream stall, and raises a per-tile completion pulse. It sits between the quantiser and the output SRAM banks.

---
 rtl/write_out_tiled_pkg.sv | 26 ++
 rtl/write_out_tiled_diag_deskew.sv | 47 ++++
 rtl/write_out_tiled.sv | 161 ++++++++++++++++
 tb/tb_write_out_tiled.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_out_tiled_pkg.sv
// Shared definitions for the tiled output writer: FSM states and
// small constant helpers used to size diagonals and slice lanes.
package write_out_tiled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Number of diagonals in one N x N tile (2N-1).
  function automatic int num_diags(input int n);
    return 2 * n - 1;
  endfunction

  // Index of the highest lane in an N-lane vector (N-1).
  function automatic int max_lane(input int n);
    return n - 1;
  endfunction

  // Bit offset of a lane inside a packed lane vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/write_out_tiled_diag_deskew.sv
// De-skew of one diagonal beat into a head vector and a tail vector.
// Output lanes are reversed: output lane k sits at lane slot N-1-k.
module diag_deskew
  import write_out_tiled_pkg::*;
#(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DIAG_BITS         = 4
) (
  input  logic [DIAG_BITS-1:0]                    diag,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] head_vec,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] tail_vec
);

  localparam int W        = OUTPUT_DATA_WIDTH;
  localparam int MAX_LANE = max_lane(ARRAY_SIZE);

  int dv;
  int sh;

  // Rising diagonals copy lanes 0..d; falling diagonals shift the head
  // down by d-N+1 lanes and spill the low lanes 0..d-N into the tail.
  always_comb begin
    head_vec = '0;
    tail_vec = '0;
    dv       = int'(diag);
    sh       = dv - ARRAY_SIZE + 1;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (dv < ARRAY_SIZE) begin
        if (i <= dv) begin
          head_vec[lane_lsb(MAX_LANE - i, W) +: W] = in_data[lane_lsb(i, W) +: W];
        end
      end else begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          if (j == i + sh) begin
            head_vec[lane_lsb(MAX_LANE - i, W) +: W] = in_data[lane_lsb(j, W) +: W];
          end
        end
        if (i < sh) begin
          tail_vec[lane_lsb(MAX_LANE - i, W) +: W] = in_data[lane_lsb(i, W) +: W];
        end
      end
    end
  end

endmodule

// File: rtl/write_out_tiled.sv
// Tiled output writer: accepts skewed diagonal beats, tracks diagonal and
// tile position, and writes de-skewed rows into NUM_SETS+1 SRAM banks.
module write_out_tiled
  import write_out_tiled_pkg::*;
#(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int NUM_SETS          = 2,
  parameter int SET_BITS          = 1,
  parameter int TILES_PER_BANK    = 4,
  parameter int ADDR_BITS         = 5,
  parameter int DIAG_BITS         = 4
) (
  input  logic                                               clk,
  input  logic                                               srstn,
  input  logic                                               clear,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]            in_data,
  input  logic [SET_BITS-1:0]                                in_set,
  input  logic                                               sram_stall,
  output logic [NUM_SETS:0]                                  sram_we_n,
  output logic [(NUM_SETS+1)*ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata,
  output logic [(NUM_SETS+1)*ADDR_BITS-1:0]                  sram_waddr,
  output logic                                               tile_done,
  output logic                                               set_err
);

  localparam int DIAGS     = num_diags(ARRAY_SIZE);
  localparam int NUM_BANKS = NUM_SETS + 1;
  localparam int LANES_W   = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int TILE_BITS = (TILES_PER_BANK > 1) ? $clog2(TILES_PER_BANK) : 1;

  state_t                state;
  state_t                state_nxt;
  logic [DIAG_BITS-1:0]  diag;
  logic [DIAG_BITS-1:0]  cur_diag;
  logic [TILE_BITS-1:0]  tile_idx;
  logic [SET_BITS-1:0]   set_reg;
  logic [SET_BITS-1:0]   cur_set;
  logic                  accept;
  logic                  last_beat;
  logic                  set_ok;
  logic                  has_tail;
  logic [ADDR_BITS-1:0]  base_addr;
  logic [ADDR_BITS-1:0]  head_addr;
  logic [ADDR_BITS-1:0]  tail_addr;
  logic [LANES_W-1:0]    head_vec;
  logic [LANES_W-1:0]    tail_vec;

  assign set_ok    = int'(cur_set) < NUM_SETS;
  assign has_tail  = int'(cur_diag) >= ARRAY_SIZE;
  assign base_addr = ADDR_BITS'(tile_idx) * ADDR_BITS'(DIAGS);
  assign head_addr = base_addr + ADDR_BITS'(cur_diag);
  assign tail_addr = head_addr - ADDR_BITS'(ARRAY_SIZE);

  diag_deskew #(
    .ARRAY_SIZE        (ARRAY_SIZE),
    .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
    .DIAG_BITS         (DIAG_BITS)
  ) u_deskew (
    .diag     (cur_diag),
    .in_data  (in_data),
    .head_vec (head_vec),
    .tail_vec (tail_vec)
  );

  // State register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake and the diagonal/set seen by the current beat;
  // clear overrides everything and blocks acceptance in its own cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tile_done = 1'b0;
    cur_diag  = '0;
    cur_set   = in_set;
    case (state)
      ST_IDLE: begin
        in_ready = ~sram_stall;
      end
      ST_RUN: begin
        in_ready = ~sram_stall;
        cur_diag = diag + DIAG_BITS'(1);
        cur_set  = set_reg;
      end
      ST_DONE: begin
        tile_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (clear) begin
      in_ready  = 1'b0;
      tile_done = 1'b0;
      state_nxt = ST_IDLE;
    end
    accept    = in_valid & in_ready;
    last_beat = (cur_diag == DIAG_BITS'(DIAGS - 1));
    if (accept) begin
      state_nxt = last_beat ? ST_DONE : ST_RUN;
    end
  end

  // Diagonal, tile and set tracking; the tile index advances once per tile.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      diag     <= '0;
      tile_idx <= '0;
      set_reg  <= '0;
    end else if (clear) begin
      diag     <= '0;
      tile_idx <= '0;
    end else if (state == ST_DONE) begin
      diag     <= '0;
      tile_idx <= (tile_idx == TILE_BITS'(TILES_PER_BANK - 1)) ? '0 : tile_idx + TILE_BITS'(1);
    end else if (accept) begin
      diag <= cur_diag;
      if (state == ST_IDLE) begin
        set_reg <= in_set;
      end
    end
  end

  // Registered bank writes: head to bank s, tail to bank s+1; banks not
  // written this cycle keep their previous data and address.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      sram_we_n  <= '1;
      sram_wdata <= '0;
      sram_waddr <= '0;
      set_err    <= 1'b0;
    end else begin
      set_err <= accept & (state == ST_IDLE) & ~set_ok;
      for (int b = 0; b < NUM_BANKS; b++) begin
        sram_we_n[b] <= 1'b1;
        if (accept && set_ok) begin
          if (int'(cur_set) == b) begin
            sram_we_n[b]                           <= 1'b0;
            sram_wdata[b*LANES_W +: LANES_W]       <= head_vec;
            sram_waddr[b*ADDR_BITS +: ADDR_BITS]   <= head_addr;
          end else if (has_tail && (int'(cur_set) + 1 == b)) begin
            sram_we_n[b]                           <= 1'b0;
            sram_wdata[b*LANES_W +: LANES_W]       <= tail_vec;
            sram_waddr[b*ADDR_BITS +: ADDR_BITS]   <= tail_addr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_write_out_tiled.sv
// Scoreboard bench for write_out_tiled with N=4, W=8, two data sets.
module tb_write_out_tiled;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int NS    = 2;
  localparam int SB    = 2;
  localparam int TPB   = 4;
  localparam int AB    = 5;
  localparam int DB    = 3;
  localparam int NB    = NS + 1;
  localparam int LW    = N * W;
  localparam int DIAGS = 2 * N - 1;
  localparam int CW    = 128;

  logic            clk        = 1'b0;
  logic            srstn      = 1'b1;
  logic            clear      = 1'b0;
  logic            in_valid   = 1'b0;
  logic            sram_stall = 1'b0;
  logic [LW-1:0]   in_data    = '0;
  logic [SB-1:0]   in_set     = '0;
  logic            in_ready;
  logic [NB-1:0]   sram_we_n;
  logic [NB*LW-1:0] sram_wdata;
  logic [NB*AB-1:0] sram_waddr;
  logic            tile_done;
  logic            set_err;

  typedef struct {
    int               cyc;
    logic [NB-1:0]    we_n;
    logic [NB*LW-1:0] wdata;
    logic [NB*AB-1:0] waddr;
  } wr_t;

  wr_t wq[$];
  int  doneq[$];
  int  errq[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  int m_beat = 0;
  int m_tile = 0;
  int m_set  = 0;
  bit m_done = 1'b0;

  write_out_tiled #(
    .ARRAY_SIZE        (N),
    .OUTPUT_DATA_WIDTH (W),
    .NUM_SETS          (NS),
    .SET_BITS          (SB),
    .TILES_PER_BANK    (TPB),
    .ADDR_BITS         (AB),
    .DIAG_BITS         (DB)
  ) dut (
    .clk        (clk),
    .srstn      (srstn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_set     (in_set),
    .sram_stall (sram_stall),
    .sram_we_n  (sram_we_n),
    .sram_wdata (sram_wdata),
    .sram_waddr (sram_waddr),
    .tile_done  (tile_done),
    .set_err    (set_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected bank image for one diagonal beat, straight from the placement rules.
  function automatic wr_t buildWrite(input int d, input int s, input int tile,
                                     input logic [LW-1:0] data, input int stamp);
    wr_t r;
    int base;
    logic [LW-1:0] head;
    logic [LW-1:0] tail;
    r.cyc   = stamp;
    r.we_n  = '1;
    r.wdata = '0;
    r.waddr = '0;
    head    = '0;
    tail    = '0;
    base    = tile * DIAGS;
    if (d < N) begin
      for (int k = 0; k <= d; k++) head[(N-1-k)*W +: W] = data[k*W +: W];
    end else begin
      for (int k = 0; k <= 2*N-2-d; k++) head[(N-1-k)*W +: W] = data[(k+d-N+1)*W +: W];
      for (int k = 0; k <= d-N; k++) tail[(N-1-k)*W +: W] = data[k*W +: W];
      r.we_n[s+1]             = 1'b0;
      r.wdata[(s+1)*LW +: LW] = tail;
      r.waddr[(s+1)*AB +: AB] = AB'(base + d - N);
    end
    r.we_n[s]           = 1'b0;
    r.wdata[s*LW +: LW] = head;
    r.waddr[s*AB +: AB] = AB'(base + d);
    return r;
  endfunction

  task automatic resetModel();
    m_beat = 0;
    m_tile = 0;
    m_set  = 0;
    m_done = 1'b0;
    wq.delete();
    doneq.delete();
    errq.delete();
  endtask

  // One clock of stimulus; the model decides acceptance and queues expectations.
  task automatic applyStimulus(input bit v, input logic [LW-1:0] data, input int s,
                               input bit stall, input bit clr, output bit acc);
    bit exp_ready;
    int d;
    @(negedge clk);
    in_valid   = v;
    in_data    = data;
    in_set     = SB'(s);
    sram_stall = stall;
    clear      = clr;
    #1;
    exp_ready = !clr && !m_done && !stall;
    checkOutput("in_ready", in_ready, exp_ready);
    acc = v && exp_ready;
    if (clr) begin
      m_beat = 0;
      m_done = 1'b0;
      m_tile = 0;
    end else if (m_done) begin
      doneq.push_back(cyc);
      m_done = 1'b0;
      m_tile = (m_tile + 1) % TPB;
    end else if (acc) begin
      d = m_beat;
      if (d == 0) begin
        m_set = s;
        if (s >= NS) errq.push_back(cyc + 1);
      end
      if (m_set < NS) wq.push_back(buildWrite(d, m_set, m_tile, data, cyc + 1));
      m_beat++;
      if (m_beat == DIAGS) begin
        m_beat = 0;
        m_done = 1'b1;
      end
    end
  endtask

  // Feeds one tile; optional stall before beat stall_at, optional abort at clear_at.
  task automatic sendTile(input int s, input bit pattern, input int stall_at, input int clear_at);
    bit acc;
    int tries;
    logic [LW-1:0] data;
    for (int d = 0; d < DIAGS; d++) begin
      for (int k = 0; k < N; k++) data[k*W +: W] = pattern ? W'(16*d + k) : W'($urandom);
      if (d == clear_at) begin
        applyStimulus(1'b1, data, s, 1'b0, 1'b1, acc);
        return;
      end
      if (d == stall_at) repeat (3) applyStimulus(1'b1, data, s, 1'b1, 1'b0, acc);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 20) begin
        applyStimulus(1'b1, data, s, 1'b0, 1'b0, acc);
        tries++;
      end
      if (!acc) checkOutput("accept_timeout", 0, 1);
    end
  endtask

  // Drops srstn between clock edges while a write is on the bank outputs.
  task automatic asyncResetTest();
    bit acc;
    logic [LW-1:0] data;
    applyStimulus(1'b0, '0, 0, 1'b0, 1'b1, acc);
    data = 32'h0302_0100;
    applyStimulus(1'b1, data, 0, 1'b0, 1'b0, acc);
    data = 32'h1312_1110;
    applyStimulus(1'b1, data, 0, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_we_n0", sram_we_n[0], 1'b0);
    #1;
    srstn = 1'b0;
    #1;
    checkOutput("rst_async_we_n", sram_we_n, {NB{1'b1}});
    checkOutput("rst_async_wdata", sram_wdata, 0);
    checkOutput("rst_async_waddr", sram_waddr, 0);
    in_valid = 1'b0;
    clear    = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    srstn = 1'b1;
  endtask

  // Monitor: every cycle compares bank writes, tile_done and set_err to the queues.
  initial begin
    wr_t e;
    bit  exp_done;
    bit  exp_err;
    forever begin
      @(negedge clk);
      #2;
      if (srstn) begin
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          e = wq.pop_front();
          checkOutput("we_n", sram_we_n, e.we_n);
          for (int b = 0; b < NB; b++) begin
            if (!e.we_n[b]) begin
              checkOutput($sformatf("wdata_b%0d", b), sram_wdata[b*LW +: LW], e.wdata[b*LW +: LW]);
              checkOutput($sformatf("waddr_b%0d", b), sram_waddr[b*AB +: AB], e.waddr[b*AB +: AB]);
            end
          end
        end else begin
          checkOutput("we_n_idle", sram_we_n, {NB{1'b1}});
        end
        exp_done = (doneq.size() > 0 && doneq[0] == cyc);
        if (exp_done) void'(doneq.pop_front());
        checkOutput("tile_done", tile_done, exp_done);
        exp_err = (errq.size() > 0 && errq[0] == cyc);
        if (exp_err) void'(errq.pop_front());
        checkOutput("set_err", set_err, exp_err);
      end
    end
  end

  initial begin
    bit acc;
    logic [LW-1:0] rd;
    #2 srstn = 1'b0;
    #1;
    checkOutput("rst_we_n", sram_we_n, {NB{1'b1}});
    checkOutput("rst_wdata", sram_wdata, 0);
    checkOutput("rst_waddr", sram_waddr, 0);
    checkOutput("rst_tile_done", tile_done, 0);
    checkOutput("rst_set_err", set_err, 0);
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    applyStimulus(1'b0, '0, 0, 1'b0, 1'b0, acc);

    $display("[TB] directed tiles");
    sendTile(0, 1'b1, -1, -1);
    sendTile(1, 1'b1, -1, -1);
    sendTile(0, 1'b0, -1, -1);
    sendTile(1, 1'b0, -1, -1);
    sendTile(0, 1'b1, -1, -1);
    sendTile(1, 1'b1,  2, -1);
    sendTile(3, 1'b1, -1, -1);
    sendTile(0, 1'b1, -1,  4);
    sendTile(1, 1'b1, -1, -1);

    $display("[TB] randomized traffic");
    repeat (800) begin
      rd = $urandom;
      applyStimulus($urandom_range(0, 9) < 8, rd, int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0, acc);
    end
    repeat (3) applyStimulus(1'b0, '0, 0, 1'b0, 1'b0, acc);

    $display("[TB] asynchronous reset");
    asyncResetTest();
    sendTile(0, 1'b1, -1, -1);
    sendTile(1, 1'b0, -1, -1);
    repeat (4) applyStimulus(1'b0, '0, 0, 1'b0, 1'b0, acc);

    checkOutput("write_queue_drained", wq.size(), 0);
    checkOutput("done_queue_drained", doneq.size(), 0);
    checkOutput("err_queue_drained", errq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
